pdp_mem_arbiter: RTL and testbench

PDP_MEM_ARBITER -- requirements
Module: pdp_mem_arbiter

---
 rtl/pdp_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_pdp_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_mem_arbiter.sv
// pdp_mem_arbiter
//   Arbitrates one single-port memory between the instruction fetch unit
//   (ifu, read-only) and the execution unit (exec, read/write). Exec wins by
//   default; the ifu is forced through after STARVE_LIMIT consecutive exec
//   grants made while it was waiting. One transaction per grant, all state
//   and outputs registered.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   ifu_rd_req/addr     fetch request (level) and address
//   ifu_rd_data/valid   fetched word and its one-cycle valid pulse
//   exec_rd_req/wr_req  exec read / write requests (level)
//   exec_addr/wdata     exec address and write data
//   exec_rd_data/done   exec read data and one-cycle completion pulse
//   mem_req/we/addr/wdata  memory command, held until mem_ack
//   mem_rdata/ack       memory read data and completion strobe
//   busy                FSM not idle
//   req_err             sticky protocol error (cleared only by reset)

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ifu_rd_req,
  input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [`DATA_WIDTH-1:0] ifu_rd_data,
  output logic                   ifu_rd_valid,
  input  logic                   exec_rd_req,
  input  logic                   exec_wr_req,
  input  logic [`ADDR_WIDTH-1:0] exec_addr,
  input  logic [`DATA_WIDTH-1:0] exec_wdata,
  output logic [`DATA_WIDTH-1:0] exec_rd_data,
  output logic                   exec_done,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [`ADDR_WIDTH-1:0] mem_addr,
  output logic [`DATA_WIDTH-1:0] mem_wdata,
  input  logic [`DATA_WIDTH-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic                   busy,
  output logic                   req_err
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IFU_ACC, EXE_ACC, RESP} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          starve_cnt, starve_cnt_nxt;
  logic                   mem_req_nxt, mem_we_nxt;
  logic [`ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [`DATA_WIDTH-1:0] mem_wdata_nxt;
  logic [`DATA_WIDTH-1:0] ifu_rd_data_nxt, exec_rd_data_nxt;
  logic                   ifu_rd_valid_nxt, exec_done_nxt;
  logic                   busy_nxt, req_err_nxt;
  logic                   exec_any, starved, ifu_win;

  assign exec_any = exec_rd_req | exec_wr_req;
  assign starved  = (starve_cnt == CW'(STARVE_LIMIT));
  assign ifu_win  = ifu_rd_req & (~exec_any | starved);

  always_comb begin
    state_nxt        = state;
    starve_cnt_nxt   = starve_cnt;
    mem_req_nxt      = mem_req;
    mem_we_nxt       = mem_we;
    mem_addr_nxt     = mem_addr;
    mem_wdata_nxt    = mem_wdata;
    ifu_rd_data_nxt  = ifu_rd_data;
    exec_rd_data_nxt = exec_rd_data;
    ifu_rd_valid_nxt = 1'b0;
    exec_done_nxt    = 1'b0;
    req_err_nxt      = req_err;

    // An ack with no access in flight is discarded but remembered as an error.
    if (mem_ack && !(state == IFU_ACC || state == EXE_ACC))
      req_err_nxt = 1'b1;

    unique case (state)
      IDLE: begin
        if (ifu_win) begin
          state_nxt      = IFU_ACC;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = 1'b0;
          mem_addr_nxt   = ifu_rd_addr;
          mem_wdata_nxt  = '0;
          starve_cnt_nxt = '0;
        end else if (exec_any) begin
          state_nxt     = EXE_ACC;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = exec_wr_req;   // write wins a rd/wr collision
          mem_addr_nxt  = exec_addr;
          mem_wdata_nxt = exec_wdata;
          if (exec_rd_req && exec_wr_req)
            req_err_nxt = 1'b1;
          if (ifu_rd_req && !starved)
            starve_cnt_nxt = starve_cnt + CW'(1);
        end
      end
      IFU_ACC: begin
        if (mem_ack) begin
          state_nxt        = RESP;
          mem_req_nxt      = 1'b0;
          ifu_rd_data_nxt  = mem_rdata;
          ifu_rd_valid_nxt = 1'b1;
        end
      end
      EXE_ACC: begin
        if (mem_ack) begin
          state_nxt     = RESP;
          mem_req_nxt   = 1'b0;
          mem_we_nxt    = 1'b0;
          exec_done_nxt = 1'b1;
          if (!mem_we)
            exec_rd_data_nxt = mem_rdata;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ifu_rd_data  <= '0;
      ifu_rd_valid <= 1'b0;
      exec_rd_data <= '0;
      exec_done    <= 1'b0;
      busy         <= 1'b0;
      req_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      starve_cnt   <= starve_cnt_nxt;
      mem_req      <= mem_req_nxt;
      mem_we       <= mem_we_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      ifu_rd_data  <= ifu_rd_data_nxt;
      ifu_rd_valid <= ifu_rd_valid_nxt;
      exec_rd_data <= exec_rd_data_nxt;
      exec_done    <= exec_done_nxt;
      busy         <= busy_nxt;
      req_err      <= req_err_nxt;
    end
  end

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// tb_pdp_mem_arbiter
//   Directed bench for pdp_mem_arbiter: a small memory responder with a
//   programmable ack wait, and hand-computed expectations sampled on the
//   falling clock edge.

`timescale 1ns/1ps

module tb_pdp_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic        ifu_rd_valid;
  logic        exec_rd_req, exec_wr_req;
  logic [11:0] exec_addr, exec_wdata, exec_rd_data;
  logic        exec_done;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr, mem_wdata;
  logic [11:0] mem_rdata;
  logic        mem_ack;
  logic        busy, req_err;

  int errors = 0;
  int checks = 0;

  // responder controls
  int          ack_wait  = 0;
  int          wcnt      = 0;
  logic        stray_ack = 1'b0;
  logic [11:0] rdata_val = '0;

  pdp_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .ifu_rd_valid(ifu_rd_valid),
    .exec_rd_req(exec_rd_req), .exec_wr_req(exec_wr_req),
    .exec_addr(exec_addr), .exec_wdata(exec_wdata),
    .exec_rd_data(exec_rd_data), .exec_done(exec_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .req_err(req_err)
  );

  always #5 clk = ~clk;

  // Memory: ack in the (ack_wait+1)-th cycle of mem_req.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ack   = (wcnt == ack_wait);
        mem_rdata = rdata_val;
        wcnt      = wcnt + 1;
      end else begin
        mem_ack = stray_ack;
        wcnt    = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  int  n;
  int  budget;
  logic prev_req;
  logic [5:0] grant_ifu;
  logic [5:0] exp_grant;

  initial begin
    reset_n = 1'b0; ifu_rd_req = 1'b0; ifu_rd_addr = '0;
    exec_rd_req = 1'b0; exec_wr_req = 1'b0; exec_addr = '0; exec_wdata = '0;
    do_reset();

    // reset state (sampled while still reset-clean, before any request)
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_err", 32'(req_err), 32'd0);
    check("rst_ifu_data", 32'(ifu_rd_data), 32'd0);
    check("rst_exec_data", 32'(exec_rd_data), 32'd0);

    // zero-wait ifu fetch
    ack_wait = 0; rdata_val = 12'o7001;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
    tick();  // cycle 1
    check("ifu_mem_req_c1", 32'(mem_req), 32'd1);
    check("ifu_mem_addr", 32'(mem_addr), 32'o0200);
    check("ifu_mem_we", 32'(mem_we), 32'd0);
    check("ifu_valid_c1", 32'(ifu_rd_valid), 32'd0);
    check("ifu_busy_c1", 32'(busy), 32'd1);
    tick();  // cycle 2
    check("ifu_valid_c2", 32'(ifu_rd_valid), 32'd1);
    check("ifu_data", 32'(ifu_rd_data), 32'o7001);
    check("ifu_mem_req_c2", 32'(mem_req), 32'd0);
    ifu_rd_req = 1'b0;
    tick();
    check("ifu_valid_c3", 32'(ifu_rd_valid), 32'd0);
    check("ifu_idle_c3", 32'(busy), 32'd0);

    // exec first when both request, ifu next
    rdata_val = 12'o4321;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0300;
    exec_rd_req = 1'b1; exec_addr = 12'o0050;
    tick();
    check("arb_exec_addr", 32'(mem_addr), 32'o0050);
    check("arb_exec_we", 32'(mem_we), 32'd0);
    rdata_val = 12'o5555;
    tick();
    check("arb_exec_done", 32'(exec_done), 32'd1);
    check("arb_exec_data", 32'(exec_rd_data), 32'o4321);
    check("arb_ifu_no_valid", 32'(ifu_rd_valid), 32'd0);
    exec_rd_req = 1'b0;
    tick();
    check("arb_idle", 32'(busy), 32'd0);
    tick();
    check("arb_ifu_req", 32'(mem_req), 32'd1);
    check("arb_ifu_addr", 32'(mem_addr), 32'o0300);
    tick();
    check("arb_ifu_valid", 32'(ifu_rd_valid), 32'd1);
    check("arb_ifu_data", 32'(ifu_rd_data), 32'o5555);
    check("arb_exec_hold", 32'(exec_rd_data), 32'o4321);
    ifu_rd_req = 1'b0;
    tick();

    // exec write with 3-cycle memory
    ack_wait = 2; rdata_val = 12'o6666;
    exec_wr_req = 1'b1; exec_addr = 12'o0100; exec_wdata = 12'o1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr_mem_req", 32'(mem_req), 32'd1);
      check("wr_mem_we", 32'(mem_we), 32'd1);
      check("wr_mem_wdata", 32'(mem_wdata), 32'o1234);
      check("wr_mem_addr", 32'(mem_addr), 32'o0100);
      check("wr_no_done", 32'(exec_done), 32'd0);
    end
    tick();
    check("wr_done", 32'(exec_done), 32'd1);
    check("wr_mem_req_off", 32'(mem_req), 32'd0);
    check("wr_rd_data_kept", 32'(exec_rd_data), 32'o4321);
    exec_wr_req = 1'b0;
    tick();
    check("wr_done_once", 32'(exec_done), 32'd0);

    // reset in the middle of an exec access
    ack_wait = 10;
    exec_rd_req = 1'b1; exec_addr = 12'o0070;
    tick();
    check("ab_mem_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0; exec_rd_req = 1'b0;
    tick();
    check("ab_mem_req_off", 32'(mem_req), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_addr", 32'(mem_addr), 32'd0);
    check("ab_exec_data", 32'(exec_rd_data), 32'd0);
    check("ab_ifu_data", 32'(ifu_rd_data), 32'd0);
    reset_n = 1'b1;
    tick();
    check("ab_no_done", 32'(exec_done), 32'd0);
    tick();
    check("ab_no_done2", 32'(exec_done), 32'd0);
    check("ab_still_idle", 32'(busy), 32'd0);

    // rd/wr collision: write wins, sticky error
    ack_wait = 0;
    exec_rd_req = 1'b1; exec_wr_req = 1'b1;
    exec_addr = 12'o0110; exec_wdata = 12'o2222;
    tick();
    check("col_we", 32'(mem_we), 32'd1);
    check("col_wdata", 32'(mem_wdata), 32'o2222);
    check("col_err", 32'(req_err), 32'd1);
    tick();
    check("col_done", 32'(exec_done), 32'd1);
    exec_rd_req = 1'b0; exec_wr_req = 1'b0;
    tick(); tick();
    check("col_err_sticky", 32'(req_err), 32'd1);
    do_reset();
    check("col_err_reset", 32'(req_err), 32'd0);

    // stray ack in IDLE
    stray_ack = 1'b1;
    tick(); tick();
    stray_ack = 1'b0;
    check("stray_err", 32'(req_err), 32'd1);
    check("stray_no_req", 32'(mem_req), 32'd0);
    check("stray_idle", 32'(busy), 32'd0);
    do_reset();

    // starvation: 4 exec grants, then ifu, then exec again
    check("starve_rst", 32'(dut.starve_cnt), 32'd0);
    ack_wait = 0;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
    exec_rd_req = 1'b1; exec_addr = 12'o0050;
    exp_grant = 6'b010000;  // bit k = 1 when grant k should be ifu
    n = 0; budget = 0; prev_req = 1'b0;
    while (n < 6 && budget < 60) begin
      tick();
      budget++;
      if (mem_req && !prev_req) begin
        grant_ifu[n] = (mem_addr == 12'o0200);
        check($sformatf("starve_grant%0d", n), 32'(grant_ifu[n]), 32'(exp_grant[n]));
        if (n == 3) check("starve_cnt_4", 32'(dut.starve_cnt), 32'd4);
        if (n == 4) check("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);
        n++;
      end
      prev_req = mem_req;
    end
    check("starve_grants_seen", 32'(n), 32'd6);
    ifu_rd_req = 1'b0; exec_rd_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
